// File: rtl/matvec_pkg.sv
// Shared constants and types for the matrix-vector control unit.
// N is the vector length and the matrix row count; LAT is the datapath
// latency from row issue to a valid result.
package matvec_pkg;

    localparam int N   = 8;
    localparam int LAT = 3;
    localparam int XW  = $clog2(N);
    localparam int WW  = 2 * XW;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_X  = 3'd1,
        LOAD_W  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // True when a counter sits on its final value before wrapping.
    function automatic logic at_last(input logic [WW-1:0] cnt, input int limit);
        return cnt == WW'(limit - 1);
    endfunction

endpackage

// File: rtl/matvec_ctrl_part4_if.sv
// Upstream load stream and downstream result stream of the control unit.
// master: the control block; slave: the surrounding producer and consumer.
interface matvec_ctrl_part4_if;
    import matvec_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          result_valid;
    logic          result_ready;
    logic [XW-1:0] result_idx;

    modport master (
        input  in_valid,
        input  result_ready,
        output in_ready,
        output result_valid,
        output result_idx
    );

    modport slave (
        output in_valid,
        output result_ready,
        input  in_ready,
        input  result_valid,
        input  result_idx
    );

endinterface

// File: rtl/matvec_pipe_tracker.sv
// LAT-deep valid shift register shadowing the datapath pipeline.
// Everything freezes while a presented result is not accepted, so no
// result can be overwritten or presented twice.
module matvec_pipe_tracker
    import matvec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic run,           // COMPUTE or DRAIN: datapath pipeline is live
    input  logic issue,         // a new row enters the pipeline this cycle
    input  logic result_ready,
    output logic advance,
    output logic en_pipe,
    output logic en_acc,
    output logic result_valid
);

    // v_reg[k] marks a live row k cycles after issue; v_reg[LAT] is the
    // row currently sitting in the datapath result register.
    logic [LAT:1] v_reg;

    assign result_valid = v_reg[LAT];
    assign advance      = !(v_reg[LAT] && !result_ready);
    assign en_pipe      = advance && run;
    assign en_acc       = v_reg[LAT-1] && advance;

    // Shift valid bits forward whenever the output stage is free to move.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
        end else if (advance) begin
            v_reg[1] <= issue;
            for (int k = 2; k <= LAT; k++) begin
                v_reg[k] <= v_reg[k-1];
            end
        end
    end

endmodule

// File: rtl/matvec_ctrl_part4.sv
// Control unit for datapath_part4: sequences loading of the x vector and
// the W matrix from an upstream stream, then issues the N rows and hands
// each result to a downstream consumer with backpressure.
// Optional build macro MATVEC_CTRL_WEIGHT_REUSE_EN adds a reuse_w input
// that skips reloading W when a complete matrix is already resident.
module matvec_ctrl_part4
    import matvec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
    input  logic                 reuse_w,
`endif
    matvec_ctrl_part4_if.master  bus,
    output logic [XW-1:0]        addr_x,
    output logic                 wr_en_x,
    output logic [WW-1:0]        addr_w,
    output logic                 wr_en_w,
    output logic                 clear_acc,
    output logic                 en_acc,
    output logic                 en_pipe,
    output logic                 busy,
    output logic                 done
);

    state_t        state_reg;
    logic [XW-1:0] xcnt_reg;
    logic [WW-1:0] wcnt_reg;
    logic [XW-1:0] rowcnt_reg;
    logic [XW-1:0] result_idx_reg;
    logic          done_reg;

    logic          in_ready_c;
    logic          accept;
    logic          advance;
    logic          issue;
    logic          run;
    logic          result_valid;
    logic          handshake;
    logic          skip_w;

`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
    logic          w_loaded_reg;
    logic          skip_w_reg;
    assign skip_w = skip_w_reg;
`else
    assign skip_w = 1'b0;
`endif

    assign run       = (state_reg == COMPUTE) || (state_reg == DRAIN);
    assign issue     = (state_reg == COMPUTE) && advance;
    assign accept    = bus.in_valid && in_ready_c;
    assign handshake = result_valid && bus.result_ready;

    matvec_pipe_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .issue        (issue),
        .result_ready (bus.result_ready),
        .advance      (advance),
        .en_pipe      (en_pipe),
        .en_acc       (en_acc),
        .result_valid (result_valid)
    );

    assign bus.in_ready     = in_ready_c;
    assign bus.result_valid = result_valid;
    assign bus.result_idx   = result_idx_reg;
    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;

    // Datapath strobes and addresses decoded from the current state.
    always_comb begin
        in_ready_c = 1'b0;
        addr_x     = '0;
        wr_en_x    = 1'b0;
        addr_w     = '0;
        wr_en_w    = 1'b0;
        clear_acc  = 1'b0;
        case (state_reg)
            IDLE: begin
                clear_acc = start;
            end
            LOAD_X: begin
                in_ready_c = 1'b1;
                wr_en_x    = bus.in_valid;
                addr_x     = xcnt_reg;
            end
            LOAD_W: begin
                in_ready_c = 1'b1;
                wr_en_w    = bus.in_valid;
                addr_w     = wcnt_reg;
            end
            COMPUTE: begin
                addr_w = {rowcnt_reg, {XW{1'b0}}};
            end
            default: begin
            end
        endcase
    end

    // Job sequencer: state, load/issue/result counters and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            xcnt_reg       <= '0;
            wcnt_reg       <= '0;
            rowcnt_reg     <= '0;
            result_idx_reg <= '0;
            done_reg       <= 1'b0;
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
            w_loaded_reg   <= 1'b0;
            skip_w_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (handshake) begin
                result_idx_reg <= result_idx_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD_X;
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
                        skip_w_reg <= reuse_w && w_loaded_reg;
`endif
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        if (xcnt_reg == XW'(N - 1)) begin
                            xcnt_reg  <= '0;
                            state_reg <= skip_w ? COMPUTE : LOAD_W;
                        end else begin
                            xcnt_reg <= xcnt_reg + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (accept) begin
                        if (at_last(wcnt_reg, N * N)) begin
                            wcnt_reg  <= '0;
                            state_reg <= COMPUTE;
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
                            w_loaded_reg <= 1'b1;
`endif
                        end else begin
                            wcnt_reg <= wcnt_reg + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (issue) begin
                        if (rowcnt_reg == XW'(N - 1)) begin
                            rowcnt_reg <= '0;
                            state_reg  <= DRAIN;
                        end else begin
                            rowcnt_reg <= rowcnt_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && (result_idx_reg == XW'(N - 1))) begin
                        done_reg       <= 1'b1;
                        state_reg      <= IDLE;
                        result_idx_reg <= '0;
                        rowcnt_reg     <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_ctrl_part4.sv
// Bench for matvec_ctrl_part4: a behavioural datapath steered by the
// control outputs, with results checked against y = W*x computed directly.
`timescale 1ns/1ps
module tb_matvec_ctrl_part4;
    import matvec_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
    logic          reuse_w;
`endif
    logic [15:0]   input_data;
    logic [XW-1:0] addr_x;
    logic          wr_en_x;
    logic [WW-1:0] addr_w;
    logic          wr_en_w;
    logic          clear_acc;
    logic          en_acc;
    logic          en_pipe;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matvec_ctrl_part4_if ifc ();

    matvec_ctrl_part4 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
        .reuse_w   (reuse_w),
`endif
        .bus       (ifc),
        .addr_x    (addr_x),
        .wr_en_x   (wr_en_x),
        .addr_w    (addr_w),
        .wr_en_w   (wr_en_w),
        .clear_acc (clear_acc),
        .en_acc    (en_acc),
        .en_pipe   (en_pipe),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural datapath: memories, two pipeline stages, result register.
    logic [15:0]   x_mem [N];
    logic [15:0]   w_mem [N*N];
    logic [XW-1:0] p1_row;
    logic [31:0]   p2_sum;
    logic [31:0]   acc;
    logic [31:0]   output_data;
    assign output_data = acc;

    function automatic logic [31:0] row_dot(input logic [XW-1:0] r);
        logic [31:0] s;
        s = '0;
        for (int c = 0; c < N; c++) s += 32'(w_mem[int'(r) * N + c]) * 32'(x_mem[c]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= input_data;
        if (wr_en_w) w_mem[addr_w] <= input_data;
        if (en_pipe) begin
            p1_row <= addr_w[WW-1:XW];
            p2_sum <= row_dot(p1_row);
        end
        if (clear_acc) acc <= '0;
        else if (en_acc) acc <= p2_sum;
    end

    // Reference operands kept across jobs so a reuse job can see old W.
    int xv [N];
    int wm [N*N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_in_ready"}, 32'(ifc.in_ready), 0);
        chk({tag, "_result_valid"}, 32'(ifc.result_valid), 0);
        chk({tag, "_result_idx"}, 32'(ifc.result_idx), 0);
        chk({tag, "_wr_en"}, {30'd0, wr_en_x, wr_en_w}, 0);
        chk({tag, "_acc_pipe"}, {29'd0, clear_acc, en_acc, en_pipe}, 0);
        chk({tag, "_addr"}, {23'd0, addr_x, addr_w}, 0);
    endtask

    // One job, cycle by cycle: inputs driven at negedge, outputs checked 1ns later.
    task automatic run_job(input bit ident, input bit gaps, input bit rnd_ready, input bit reuse,
                           input int stall_idx, input int poke_cyc, input int abort_w,
                           input bit timing);
        int  y [N];
        int  words [$];
        int  wp, exp_x, exp_w, exp_idx, ndone, stall_left;
        int  t_x, t_w, t_r, t_done;
        bit  prev_stall;
        logic [31:0] prev_data;

        for (int c = 0; c < N; c++) xv[c] = ident ? c + 1 : int'($urandom_range(0, 255));
        if (!reuse)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    wm[r*N+c] = ident ? ((r == c) ? 1 : 0) : int'($urandom_range(0, 255));
        for (int r = 0; r < N; r++) begin
            y[r] = 0;
            for (int c = 0; c < N; c++) y[r] += wm[r*N+c] * xv[c];
        end
        words.delete();
        for (int c = 0; c < N; c++) words.push_back(xv[c]);
        if (!reuse) for (int i = 0; i < N*N; i++) words.push_back(wm[i]);

        wp = 0; exp_x = 0; exp_w = 0; exp_idx = 0; ndone = 0; stall_left = 5;
        t_x = -1; t_w = -1; t_r = -1; t_done = -1;
        prev_stall = 1'b0; prev_data = '0;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == poke_cyc);
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
            reuse_w = reuse;
`endif
            if (wp < words.size()) begin
                ifc.in_valid = gaps ? c[0] : 1'b1;
                input_data   = 16'(words[wp]);
            end else begin
                ifc.in_valid = 1'($urandom_range(0, 1));
                input_data   = 16'($urandom);
            end
            if (ifc.result_valid && (int'(ifc.result_idx) == stall_idx) && stall_left > 0) begin
                ifc.result_ready = 1'b0;
                stall_left--;
            end else begin
                ifc.result_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            if (wr_en_x) begin
                if (t_x < 0) t_x = c;
                chk("addr_x", 32'(addr_x), 32'(exp_x));
                chk("wr_x_needs_valid", 32'(ifc.in_valid), 1);
                exp_x++;
            end
            if (wr_en_w) begin
                if (t_w < 0) t_w = c;
                chk("addr_w", 32'(addr_w), 32'(exp_w));
                chk("wr_w_needs_valid", 32'(ifc.in_valid), 1);
                exp_w++;
            end
            if (clear_acc || en_acc) chk("acc_exclusive", 32'(clear_acc && en_acc), 0);
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(ifc.result_valid), 1);
                chk("stall_hold_data", output_data, prev_data);
            end
            if (ifc.result_valid && !ifc.result_ready) begin
                chk("stall_en_pipe", 32'(en_pipe), 0);
                chk("stall_en_acc", 32'(en_acc), 0);
            end
            if (ifc.result_valid && ifc.result_ready) begin
                if (t_r < 0) t_r = c;
                chk("result_idx", 32'(ifc.result_idx), 32'(exp_idx));
                chk("result_data", output_data, 32'(y[exp_idx % N]));
                exp_idx++;
            end
            if (done) begin
                ndone++;
                if (t_done < 0) t_done = c;
                chk("done_not_busy", 32'(busy), 0);
            end
            prev_stall = ifc.result_valid && !ifc.result_ready;
            prev_data  = output_data;
            if (ifc.in_valid && ifc.in_ready && wp < words.size()) wp++;
            if (abort_w >= 0 && wr_en_w && int'(addr_w) == abort_w) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                #1;
                chk_idle_outputs("abort");
                return;
            end
            if (t_done >= 0 && c >= t_done + 3) break;
        end
        start = 1'b0;
        chk("results_seen", 32'(exp_idx), N);
        chk("done_count", 32'(ndone), 1);
        chk("x_writes", 32'(exp_x), N);
        chk("w_writes", 32'(exp_w), reuse ? 0 : N*N);
        if (timing) begin
            chk("t_first_x", 32'(t_x), 1);
            chk("t_first_w", 32'(t_w), reuse ? 32'hffff_ffff : 9);
            chk("t_first_result", 32'(t_r), reuse ? 12 : 76);
            chk("t_done", 32'(t_done), reuse ? 20 : 84);
        end
        $display("job: gaps=%0d rnd_ready=%0d reuse=%0d stall=%0d results=%0d done=%0d first_result=%0d",
                 gaps, rnd_ready, reuse, stall_idx, exp_idx, ndone, t_r);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
        reuse_w = 1'b0;
`endif
        ifc.in_valid = 1'b0;
        ifc.result_ready = 1'b0;
        input_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ifc.in_valid = 1'b1;
        #1;
        chk_idle_outputs("reset");

        run_job(1, 0, 0, 0, -1, -1, -1, 1);      // identity W, x = 1..8
        run_job(0, 1, 0, 0, -1, -1, -1, 0);      // in_valid gaps
        run_job(0, 0, 0, 0, 2, -1, -1, 0);       // 5-cycle stall on result 2
        run_job(0, 0, 0, 0, -1, -1, 20, 0);      // reset during LOAD_W at wcnt 20
        run_job(0, 0, 0, 0, -1, -1, -1, 1);      // fresh job after reset
        run_job(0, 0, 0, 0, -1, 74, -1, 1);      // start pulsed during COMPUTE
        for (int i = 0; i < 3; i++) run_job(0, 1, 1, 0, -1, -1, -1, 0);
`ifdef MATVEC_CTRL_WEIGHT_REUSE_EN
        run_job(0, 0, 0, 1, -1, -1, -1, 1);      // reuse previously loaded W
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
